// File: rtl/or1200_checker_resp_pkg.sv
// Shared definitions for the privilege-checker response path: cause bit
// positions, FSM encodings and the supervisor-flag decode.
package or1200_checker_defs;

  localparam int NUM_SRC    = 4;
  localparam int CAUSE_SR   = 0;
  localparam int CAUSE_PIPE = 1;
  localparam int CAUSE_MMU  = 2;
  localparam int CAUSE_SUPV = 3;

  typedef enum logic [1:0] {
    MONITOR  = 2'd0,
    ALERT    = 2'd1,
    LOCKDOWN = 2'd2
  } chk_state_e;

  // Even parity on the 3-bit encoding means "supervisor".
  function automatic logic supv_decode(input logic [2:0] enc);
    return ~^enc;
  endfunction

endpackage

// File: rtl/or1200_checker_resp_filt.sv
// Single-source debounce: counts consecutive enabled violation cycles and
// pulses qual once per episode when the count reaches FILTER_CYCLES.
module or1200_checker_filt #(
  parameter int FILTER_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic check_en,
  input  logic raw,
  output logic qual
);

  localparam logic [3:0] FC = 4'(FILTER_CYCLES);

  logic [3:0] cnt;
  logic       hit;

  assign hit  = check_en & raw;
  // Counter parks at FC, so the pulse cannot repeat until raw drops.
  assign qual = hit & (cnt == FC - 4'd1);

  always_ff @(posedge clk) begin
    if (rst)          cnt <= '0;
    else if (!hit)    cnt <= '0;
    else if (cnt != FC) cnt <= cnt + 4'd1;
  end

endmodule

// File: rtl/or1200_checker_resp.sv
// Security response for the CPU privilege checker: debounces violation
// sources, records causes/statistics and escalates alert -> lockdown.
module or1200_checker_resp
  import or1200_checker_defs::*;
#(
  parameter int FILTER_CYCLES = 2,
  parameter int ACK_TIMEOUT   = 16,
  parameter int MAX_ALERTS    = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             check_en,
  input  logic             sr_ok,
  input  logic             pipeline_ok,
  input  logic             mmus_ok,
  input  logic [2:0]       secure_supv,
  input  logic             sr_sm,
  input  logic             alarm_ack,
  output logic             alarm_irq,
  output logic             freeze_req,
  output logic             lockdown,
  output logic [3:0]       cause,
  output logic [3:0]       first_cause,
  output logic [CNT_W-1:0] viol_cnt
);

  logic [NUM_SRC-1:0] raw;
  logic [NUM_SRC-1:0] qual;
  logic               any_q;

  always_comb begin
    raw             = '0;
    raw[CAUSE_SR]   = ~sr_ok;
    raw[CAUSE_PIPE] = ~pipeline_ok;
    raw[CAUSE_MMU]  = ~mmus_ok;
    raw[CAUSE_SUPV] = supv_decode(secure_supv) != sr_sm;
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_filt
    or1200_checker_filt #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt (
      .clk      (clk),
      .rst      (rst),
      .check_en (check_en),
      .raw      (raw[s]),
      .qual     (qual[s])
    );
  end

  assign any_q = |qual;

  chk_state_e state, state_n;
  logic [7:0] timer, timer_n;
  logic [7:0] alert_cnt, alert_cnt_inc;
  logic       lock_hit;
  logic       ack_clr;

  assign alert_cnt_inc = (alert_cnt == 8'hFF) ? alert_cnt : alert_cnt + 8'd1;
  assign lock_hit      = any_q & (alert_cnt_inc >= 8'(MAX_ALERTS));

  always_comb begin
    state_n = state;
    timer_n = timer;
    ack_clr = 1'b0;
    case (state)
      MONITOR: begin
        if (any_q) begin
          state_n = lock_hit ? LOCKDOWN : ALERT;
          timer_n = 8'(ACK_TIMEOUT);
        end
      end
      ALERT: begin
        if (timer != 8'd0) timer_n = timer - 8'd1;
        // Alert-count lockdown beats ack; ack beats the timeout.
        if (lock_hit) begin
          state_n = LOCKDOWN;
        end else if (alarm_ack) begin
          state_n = MONITOR;
          ack_clr = 1'b1;
        end else if (timer <= 8'd1) begin
          state_n = LOCKDOWN;
        end
      end
      LOCKDOWN: state_n = LOCKDOWN;
      default:  state_n = MONITOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MONITOR;
      timer       <= '0;
      alert_cnt   <= '0;
      alarm_irq   <= 1'b0;
      freeze_req  <= 1'b0;
      lockdown    <= 1'b0;
      cause       <= '0;
      first_cause <= '0;
      viol_cnt    <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      alarm_irq  <= state_n != MONITOR;
      freeze_req <= state_n == LOCKDOWN;
      lockdown   <= state_n == LOCKDOWN;
      cause      <= (ack_clr ? 4'd0 : cause) | qual;
      if (any_q) begin
        alert_cnt <= alert_cnt_inc;
        if (first_cause == 4'd0) first_cause <= qual;
        if (!(&viol_cnt)) viol_cnt <= viol_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_or1200_checker_resp.sv
// Directed bench: each stimulus cycle queues its hand-computed expected
// outputs; an independent monitor compares them after the clock edge.
module tb_or1200_checker_resp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       check_en = 1'b1;
  logic       sr_ok = 1'b1;
  logic       pipeline_ok = 1'b1;
  logic       mmus_ok = 1'b1;
  logic [2:0] secure_supv = 3'b001;
  logic       sr_sm = 1'b0;
  logic       alarm_ack = 1'b0;
  logic       alarm_irq, freeze_req, lockdown;
  logic [3:0] cause, first_cause;
  logic [7:0] viol_cnt;

  always #5 clk = ~clk;

  or1200_checker_resp dut (
    .clk         (clk),
    .rst         (rst),
    .check_en    (check_en),
    .sr_ok       (sr_ok),
    .pipeline_ok (pipeline_ok),
    .mmus_ok     (mmus_ok),
    .secure_supv (secure_supv),
    .sr_sm       (sr_sm),
    .alarm_ack   (alarm_ack),
    .alarm_irq   (alarm_irq),
    .freeze_req  (freeze_req),
    .lockdown    (lockdown),
    .cause       (cause),
    .first_cause (first_cause),
    .viol_cnt    (viol_cnt)
  );

  typedef struct {
    string      tag;
    int         tgt;
    logic       alarm;
    logic       lock;
    logic [3:0] cause;
    logic [3:0] first;
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].tgt == cyc) begin
      mon_e = sbq.pop_front();
      n_vec++;
      if (alarm_irq !== mon_e.alarm || freeze_req !== mon_e.lock ||
          lockdown !== mon_e.lock || cause !== mon_e.cause ||
          first_cause !== mon_e.first || viol_cnt !== mon_e.cnt) begin
        n_mis++;
        $display("FAIL %s cyc=%0d got irq=%b frz=%b lck=%b cause=%b first=%b cnt=%0d want irq=%b frz/lck=%b cause=%b first=%b cnt=%0d",
                 mon_e.tag, cyc, alarm_irq, freeze_req, lockdown, cause, first_cause,
                 viol_cnt, mon_e.alarm, mon_e.lock, mon_e.cause, mon_e.first, mon_e.cnt);
      end
    end
  end

  // Queue expected outputs for the coming edge, then let it happen.
  task automatic tick(input string t, input logic a, input logic lk,
                      input logic [3:0] c, input logic [3:0] f, input logic [7:0] n);
    exp_t e;
    e.tag = t; e.tgt = cyc + 1; e.alarm = a; e.lock = lk;
    e.cause = c; e.first = f; e.cnt = n;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tick("reset0", 0, 0, 4'h0, 4'h0, 8'd0);
    tick("reset1", 0, 0, 4'h0, 4'h0, 8'd0);
    rst = 1'b0;
    tick("idle", 0, 0, 4'h0, 4'h0, 8'd0);

    // Single-cycle glitch is filtered out
    sr_ok = 1'b0; tick("glitch", 0, 0, 4'h0, 4'h0, 8'd0);
    sr_ok = 1'b1; tick("glitch_after", 0, 0, 4'h0, 4'h0, 8'd0);

    // Two cycles qualify; visible right after the second
    sr_ok = 1'b0; tick("sr_c1", 0, 0, 4'h0, 4'h0, 8'd0);
    tick("sr_qual", 1, 0, 4'h1, 4'h1, 8'd1);
    sr_ok = 1'b1;
    for (int i = 0; i < 4; i++) tick("sr_alert", 1, 0, 4'h1, 4'h1, 8'd1);
    alarm_ack = 1'b1; tick("sr_ack", 0, 0, 4'h0, 4'h1, 8'd1);
    alarm_ack = 1'b0;

    // Supervisor flag decodes to 1 while SR[SM]=0
    secure_supv = 3'b011; tick("supv_c1", 0, 0, 4'h0, 4'h1, 8'd1);
    tick("supv_qual", 1, 0, 4'h8, 4'h1, 8'd2);
    secure_supv = 3'b001;
    for (int i = 0; i < 2; i++) tick("supv_rearm", 1, 0, 4'h8, 4'h1, 8'd2);
    alarm_ack = 1'b1; tick("supv_ack", 0, 0, 4'h0, 4'h1, 8'd2);
    alarm_ack = 1'b0; tick("supv_idle", 0, 0, 4'h0, 4'h1, 8'd2);

    // Ack on the final timer cycle wins over timeout
    mmus_ok = 1'b0; tick("mmu3_c1", 0, 0, 4'h0, 4'h1, 8'd2);
    tick("mmu3_qual", 1, 0, 4'h4, 4'h1, 8'd3);
    mmus_ok = 1'b1;
    for (int i = 0; i < 15; i++) tick("mmu3_wait", 1, 0, 4'h4, 4'h1, 8'd3);
    alarm_ack = 1'b1; tick("ack_vs_timeout", 0, 0, 4'h0, 4'h1, 8'd3);
    alarm_ack = 1'b0;

    // Fourth alert goes straight to lockdown
    mmus_ok = 1'b0; tick("mmu4_c1", 0, 0, 4'h0, 4'h1, 8'd3);
    tick("max_alerts", 1, 1, 4'h4, 4'h1, 8'd4);
    mmus_ok = 1'b1;
    alarm_ack = 1'b1; tick("lock_ack_ign", 1, 1, 4'h4, 4'h1, 8'd4);
    alarm_ack = 1'b0;
    rst = 1'b1; tick("lock_reset", 0, 0, 4'h0, 4'h0, 8'd0);
    rst = 1'b0;

    // No ack: timeout after ACK_TIMEOUT alert cycles
    sr_ok = 1'b0; tick("to_c1", 0, 0, 4'h0, 4'h0, 8'd0);
    tick("to_qual", 1, 0, 4'h1, 4'h1, 8'd1);
    sr_ok = 1'b1;
    for (int i = 0; i < 15; i++) tick("to_wait", 1, 0, 4'h1, 4'h1, 8'd1);
    tick("timeout_lock", 1, 1, 4'h1, 4'h1, 8'd1);
    alarm_ack = 1'b1; tick("to_ack_ign", 1, 1, 4'h1, 4'h1, 8'd1);
    alarm_ack = 1'b0;
    rst = 1'b1; tick("to_reset", 0, 0, 4'h0, 4'h0, 8'd0);
    rst = 1'b0;

    // Disabled monitoring blocks every source
    check_en = 1'b0; sr_ok = 1'b0; pipeline_ok = 1'b0; mmus_ok = 1'b0;
    secure_supv = 3'b011;
    for (int i = 0; i < 50; i++) tick("en_off", 0, 0, 4'h0, 4'h0, 8'd0);
    check_en = 1'b1; tick("en_c1", 0, 0, 4'h0, 4'h0, 8'd0);
    tick("en_all_qual", 1, 0, 4'hF, 4'hF, 8'd1);
    check_en = 1'b0; tick("en_off_hold", 1, 0, 4'hF, 4'hF, 8'd1);
    check_en = 1'b1; sr_ok = 1'b1; pipeline_ok = 1'b1; mmus_ok = 1'b1;
    secure_supv = 3'b001;
    alarm_ack = 1'b1; tick("all_ack", 0, 0, 4'h0, 4'hF, 8'd1);
    alarm_ack = 1'b0;

    // Long episode qualifies only once
    sr_ok = 1'b0; tick("long_c1", 0, 0, 4'h0, 4'hF, 8'd1);
    tick("long_qual", 1, 0, 4'h1, 4'hF, 8'd2);
    for (int i = 0; i < 3; i++) tick("long_hold", 1, 0, 4'h1, 4'hF, 8'd2);
    sr_ok = 1'b1;

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_mis++;
      $display("FAIL drain pending=%0d want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
